// File: rtl/audio_level_meter.sv
// Peak-hold level meter: |sample| doubled to full unsigned range, held, then decayed geometrically.
// Define AUDIO_LEVEL_METER_CLIP_EN to build the stretched clip indicator; otherwise clip is tied low.
module audio_level_meter #(
    parameter int DATA_BITS         = 24,
    parameter int HOLD_SAMPLES      = 4800,
    parameter int DECAY_SHIFT       = 10,
    parameter int CLIP_HOLD_SAMPLES = 24000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] sample_in,
    input  logic                 sample_valid,
    output logic [DATA_BITS-1:0] level_out,
    output logic                 level_valid,
    output logic                 clip
);
    localparam int HOLD_W = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
    localparam logic [HOLD_W-1:0]    HOLD_LOAD  = HOLD_W'(HOLD_SAMPLES);
    localparam logic [HOLD_W-1:0]    HOLD_ONE   = HOLD_W'(1);
    localparam logic [DATA_BITS-1:0] LEVEL_ONE  = {{(DATA_BITS-1){1'b0}}, 1'b1};
    localparam logic [DATA_BITS-1:0] FULL_SCALE = '1;

    typedef enum logic [1:0] {IDLE, HOLD, DECAY} state_t;

    state_t                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [DATA_BITS-1:0]   level_q, level_d;
    logic                   level_valid_q, level_valid_d;
    logic [DATA_BITS-1:0]   cand_q, cand_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [DATA_BITS-1:0]   mag;
    logic [DATA_BITS-1:0]   step_raw;
    logic [DATA_BITS-1:0]   step;

    // The most negative sample has magnitude 2^(DATA_BITS-1), which doubles past full scale.
    always_comb begin
        mag        = sample_in[DATA_BITS-1] ? (~sample_in + LEVEL_ONE) : sample_in;
        s1_valid_d = sample_valid;
        cand_d     = cand_q;
        if (sample_valid) begin
            cand_d = mag[DATA_BITS-1] ? FULL_SCALE : {mag[DATA_BITS-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        level_d       = level_q;
        level_valid_d = s1_valid_q;
        step_raw      = level_q >> DECAY_SHIFT;
        step          = (step_raw == '0) ? LEVEL_ONE : step_raw;
        if (s1_valid_q) begin
            case (state_q)
                IDLE: begin
                    if (cand_q != '0) begin
                        level_d    = cand_q;
                        hold_cnt_d = HOLD_LOAD;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (cand_q >= level_q) begin
                        level_d    = cand_q;
                        hold_cnt_d = HOLD_LOAD;
                    end else if (hold_cnt_q > HOLD_ONE) begin
                        hold_cnt_d = hold_cnt_q - HOLD_ONE;
                    end else begin
                        hold_cnt_d = '0;
                        state_d    = DECAY;
                    end
                end
                DECAY: begin
                    if (cand_q >= level_q) begin
                        level_d    = cand_q;
                        hold_cnt_d = HOLD_LOAD;
                        state_d    = HOLD;
                    end else begin
                        level_d = level_q - step;
                        if (level_d == '0) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    level_d    = '0;
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q        <= '0;
            s1_valid_q    <= 1'b0;
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            level_q       <= '0;
            level_valid_q <= 1'b0;
        end else begin
            cand_q        <= cand_d;
            s1_valid_q    <= s1_valid_d;
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            level_q       <= level_d;
            level_valid_q <= level_valid_d;
        end
    end

    assign level_out   = level_q;
    assign level_valid = level_valid_q;

`ifdef AUDIO_LEVEL_METER_CLIP_EN
    localparam int CLIP_W = (CLIP_HOLD_SAMPLES > 0) ? $clog2(CLIP_HOLD_SAMPLES + 1) : 1;
    localparam logic [CLIP_W-1:0]    CLIP_LOAD = CLIP_W'(CLIP_HOLD_SAMPLES);
    localparam logic [CLIP_W-1:0]    CLIP_ONE  = CLIP_W'(1);
    localparam logic [DATA_BITS-1:0] MOST_POS  = {1'b0, {(DATA_BITS-1){1'b1}}};
    localparam logic [DATA_BITS-1:0] MOST_NEG  = {1'b1, {(DATA_BITS-1){1'b0}}};

    logic              clip_s1_q, clip_s1_d;
    logic              clip_q, clip_d;
    logic [CLIP_W-1:0] clip_cnt_q, clip_cnt_d;

    // clip stays high while the counter is still non-zero, so it covers CLIP_HOLD_SAMPLES later samples.
    always_comb begin
        clip_s1_d  = clip_s1_q;
        clip_d     = clip_q;
        clip_cnt_d = clip_cnt_q;
        if (sample_valid) begin
            clip_s1_d = (sample_in == MOST_POS) || (sample_in == MOST_NEG);
        end
        if (s1_valid_q) begin
            if (clip_s1_q) begin
                clip_d     = 1'b1;
                clip_cnt_d = CLIP_LOAD;
            end else if (clip_cnt_q != '0) begin
                clip_cnt_d = clip_cnt_q - CLIP_ONE;
            end else begin
                clip_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clip_s1_q  <= 1'b0;
            clip_q     <= 1'b0;
            clip_cnt_q <= '0;
        end else begin
            clip_s1_q  <= clip_s1_d;
            clip_q     <= clip_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign clip = clip_q;
`else
    assign clip = 1'b0;
`endif

endmodule

// File: tb/tb_audio_level_meter.sv
// Directed bench for audio_level_meter with short hold/decay/clip settings.
// Clip checks follow AUDIO_LEVEL_METER_CLIP_EN exactly as the design does.
module tb_audio_level_meter;
    localparam int DATA_BITS = 24;

    logic                 clk;
    logic                 rst;
    logic [DATA_BITS-1:0] sample_in;
    logic                 sample_valid;
    logic [DATA_BITS-1:0] level_out;
    logic                 level_valid;
    logic                 clip;

    int          assert_count;
    int          fail_count;
    logic [31:0] exp_level;
    logic [31:0] exp_step;

    audio_level_meter #(
        .DATA_BITS        (DATA_BITS),
        .HOLD_SAMPLES     (4),
        .DECAY_SHIFT      (2),
        .CLIP_HOLD_SAMPLES(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .level_out   (level_out),
        .level_valid (level_valid),
        .clip        (clip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One valid sample, then wait until its result is visible (two edges later, sampled at negedge).
    task automatic applyStimulus(input logic [DATA_BITS-1:0] value);
        @(negedge clk);
        sample_in    = value;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        sample_in    = '0;
        @(negedge clk);
    endtask

    task automatic checkLevel(input string tag, input logic [31:0] expected);
        checkOutput({tag, "_level"}, 32'(level_out), expected);
        checkOutput({tag, "_valid"}, 32'(level_valid), 32'h1);
`ifndef AUDIO_LEVEL_METER_CLIP_EN
        checkOutput({tag, "_clip_off"}, 32'(clip), 32'h0);
`endif
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        rst          = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_level", 32'(level_out), 32'h0);
        checkOutput("reset_valid", 32'(level_valid), 32'h0);
        checkOutput("reset_clip", 32'(clip), 32'h0);
        rst = 1'b1;

        $display("[TB] first sample and magnitude corner cases");
        applyStimulus(24'h400000);
        checkLevel("first_peak", 32'h800000);
        @(negedge clk);
        checkOutput("valid_single_pulse", 32'(level_valid), 32'h0);
        applyStimulus(24'h800000);
        checkLevel("neg_full_scale", 32'hFFFFFF);
        doReset();
        applyStimulus(24'h7FFFFF);
        checkLevel("pos_full_scale", 32'hFFFFFE);

        $display("[TB] hold then decay");
        doReset();
        applyStimulus(24'h100000);
        checkLevel("hold_peak", 32'h200000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(24'h0);
            checkLevel("hold_keep", 32'h200000);
        end
        applyStimulus(24'h0);
        checkLevel("decay_1", 32'h180000);
        applyStimulus(24'h0);
        checkLevel("decay_2", 32'h120000);
        applyStimulus(24'h0A0000);
        checkLevel("repeak_in_decay", 32'h140000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(24'h0);
            checkLevel("rehold_keep", 32'h140000);
        end
        applyStimulus(24'h0);
        checkLevel("redecay_1", 32'h0F0000);

        exp_level = 32'h0F0000;
        for (int i = 0; i < 200 && exp_level != 32'h0; i++) begin
            exp_step = exp_level >> 2;
            if (exp_step == 32'h0) exp_step = 32'h1;
            exp_level = exp_level - exp_step;
            applyStimulus(24'h0);
            checkLevel("decay_run", exp_level);
        end
        checkOutput("decay_reached_zero", 32'(level_out), 32'h0);
        applyStimulus(24'h0);
        checkLevel("idle_zero", 32'h0);
        applyStimulus(24'h000001);
        checkLevel("idle_small", 32'h2);

        $display("[TB] asynchronous reset mid-hold");
        doReset();
        applyStimulus(24'h200000);
        checkLevel("pre_reset_peak", 32'h400000);
        applyStimulus(24'h0);
        checkLevel("pre_reset_hold", 32'h400000);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_level", 32'(level_out), 32'h0);
        checkOutput("async_reset_valid", 32'(level_valid), 32'h0);
        checkOutput("async_reset_clip", 32'(clip), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(24'h010000);
        checkLevel("post_reset_peak", 32'h020000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(24'h0);
            checkLevel("post_reset_hold", 32'h020000);
        end
        applyStimulus(24'h0);
        checkLevel("post_reset_decay", 32'h018000);

        $display("[TB] back-to-back samples from first active cycle");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst          = 1'b1;
        sample_in    = 24'h100000;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_in = 24'h200000;
        @(negedge clk);
        sample_in = 24'h050000;
        checkLevel("burst_0", 32'h200000);
        @(negedge clk);
        sample_valid = 1'b0;
        sample_in    = '0;
        checkLevel("burst_1", 32'h400000);
        @(negedge clk);
        checkLevel("burst_2", 32'h400000);
        @(negedge clk);
        checkOutput("burst_valid_end", 32'(level_valid), 32'h0);

`ifdef AUDIO_LEVEL_METER_CLIP_EN
        $display("[TB] clip stretch");
        doReset();
        checkOutput("clip_after_reset", 32'(clip), 32'h0);
        applyStimulus(24'h7FFFFF);
        checkOutput("clip_set", 32'(clip), 32'h1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(24'h0);
            checkOutput("clip_stretch", 32'(clip), 32'h1);
        end
        applyStimulus(24'h0);
        checkOutput("clip_drop", 32'(clip), 32'h0);
        applyStimulus(24'h800000);
        checkOutput("clip_neg_set", 32'(clip), 32'h1);
`endif

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
